// File: rtl/prf_rd_arb.sv
// prf_rd_arb: round-robin arbiter mapping NREQ PRF read requesters onto NPORT read ports with fixed 1-cycle response.
// Define NCPU_PRF_RD_ARB_BYPASS_EN to forward a same-cycle writeback into the response data.
module prf_rd_arb #(
  parameter int CONFIG_P_NREQ  = 2,
  parameter int CONFIG_P_NPORT = 1,
  parameter int CONFIG_PRF_AW  = 6,
  parameter int CONFIG_DW      = 64
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           flush,
  input  logic [(1<<CONFIG_P_NREQ)-1:0]                  req_valid,
  input  logic [(1<<CONFIG_P_NREQ)*CONFIG_PRF_AW-1:0]    req_addr,
  output logic [(1<<CONFIG_P_NREQ)-1:0]                  req_ready,
  output logic [(1<<CONFIG_P_NPORT)-1:0]                 prf_RE,
  output logic [(1<<CONFIG_P_NPORT)*CONFIG_PRF_AW-1:0]   prf_RADDR,
  input  logic [(1<<CONFIG_P_NPORT)*CONFIG_DW-1:0]       prf_RDATA,
  input  logic                                           wb_we,
  input  logic [CONFIG_PRF_AW-1:0]                       wb_addr,
  input  logic [CONFIG_DW-1:0]                           wb_data,
  output logic [(1<<CONFIG_P_NREQ)-1:0]                  rsp_valid,
  output logic [(1<<CONFIG_P_NREQ)*CONFIG_DW-1:0]        rsp_data
);

  localparam int unsigned NREQ   = 1 << CONFIG_P_NREQ;
  localparam int unsigned NPORT  = 1 << CONFIG_P_NPORT;
  localparam int unsigned AW     = CONFIG_PRF_AW;
  localparam int unsigned DW     = CONFIG_DW;
  localparam int unsigned PTR_W  = (CONFIG_P_NREQ > 0) ? CONFIG_P_NREQ : 1;
  localparam int unsigned PORT_W = (CONFIG_P_NPORT > 0) ? CONFIG_P_NPORT : 1;
  localparam int unsigned RANK_W = PTR_W + 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_ptr_nxt;
  logic [PTR_W-1:0]  scan_pos [NREQ];
  logic [RANK_W-1:0] rank     [NREQ];
  logic [NREQ-1:0]   gnt;
  logic [PORT_W-1:0] gnt_port   [NREQ];
  logic [PORT_W-1:0] port_idx_q [NREQ];
  logic [NREQ-1:0]   rsp_vld_q;
  logic              gnt_any;
  logic [PTR_W-1:0]  gnt_last;
  logic [PTR_W-1:0]  last_pos;

  // Scan order is expressed as each requester's distance from rr_ptr; its rank among
  // valid requesters that come earlier in the scan is also its assigned port.
  always_comb begin
    for (int unsigned j = 0; j < NREQ; j++) begin
      scan_pos[j] = PTR_W'(j) - rr_ptr;
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NREQ; j++) begin
      rank[j] = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_valid[i] && (scan_pos[i] < scan_pos[j])) begin
          rank[j] = rank[j] + RANK_W'(1);
        end
      end
    end
  end

  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_last = '0;
    last_pos = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      gnt[j]      = !flush && req_valid[j] && (rank[j] < RANK_W'(NPORT));
      gnt_port[j] = PORT_W'(rank[j]);
      if (gnt[j] && (!gnt_any || (scan_pos[j] > last_pos))) begin
        gnt_any  = 1'b1;
        gnt_last = PTR_W'(j);
        last_pos = scan_pos[j];
      end
    end
  end

  assign req_ready = gnt;

  always_comb begin
    prf_RE    = '0;
    prf_RADDR = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (gnt[j] && (rank[j] == RANK_W'(k))) begin
          prf_RE[k]              = 1'b1;
          prf_RADDR[k*AW +: AW]  = req_addr[j*AW +: AW];
        end
      end
    end
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (flush) begin
      rr_ptr_nxt = '0;
    end else if (gnt_any) begin
      rr_ptr_nxt = (NREQ == 1) ? '0 : gnt_last + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      rsp_vld_q <= '0;
      for (int unsigned j = 0; j < NREQ; j++) begin
        port_idx_q[j] <= '0;
      end
    end else begin
      rr_ptr    <= rr_ptr_nxt;
      rsp_vld_q <= gnt;
      for (int unsigned j = 0; j < NREQ; j++) begin
        port_idx_q[j] <= gnt_port[j];
      end
    end
  end

  // A flush also suppresses the response strobe already registered from the previous grant.
  assign rsp_valid = rsp_vld_q & {NREQ{~flush}};

`ifdef NCPU_PRF_RD_ARB_BYPASS_EN
  logic [NREQ-1:0] byp_hit;
  logic [NREQ-1:0] byp_hit_q;
  logic [DW-1:0]   byp_data_q;

  always_comb begin
    byp_hit = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      byp_hit[j] = gnt[j] && wb_we && (wb_addr == req_addr[j*AW +: AW]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byp_hit_q  <= '0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= byp_hit;
      byp_data_q <= wb_data;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

  always_comb begin
    rsp_data = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      for (int unsigned k = 0; k < NPORT; k++) begin
        if (port_idx_q[j] == PORT_W'(k)) begin
          rsp_data[j*DW +: DW] = prf_RDATA[k*DW +: DW];
        end
      end
`ifdef NCPU_PRF_RD_ARB_BYPASS_EN
      if (byp_hit_q[j]) begin
        rsp_data[j*DW +: DW] = byp_data_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_prf_rd_arb.sv
// Self-checking bench for prf_rd_arb (NREQ=4, NPORT=2): directed vectors plus a queue-based model checked every cycle.
module tb_prf_rd_arb;
  localparam int NREQ  = 4;
  localparam int NPORT = 2;
  localparam int AW    = 6;
  localparam int DW    = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ-1:0]       req_ready;
  logic [NPORT-1:0]      prf_re;
  logic [NPORT*AW-1:0]   prf_raddr;
  logic [NPORT*DW-1:0]   prf_rdata;
  logic                  wb_we;
  logic [AW-1:0]         wb_addr;
  logic [DW-1:0]         wb_data;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ*DW-1:0]    rsp_data;

  int checks   = 0;
  int failures = 0;

  int              m_ptr;
  logic [NREQ-1:0] m_pend;
  logic [DW-1:0]   m_data [NREQ];
  int              age    [NREQ];

  prf_rd_arb #(
    .CONFIG_P_NREQ (2),
    .CONFIG_P_NPORT(1),
    .CONFIG_PRF_AW (6),
    .CONFIG_DW     (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .prf_RE   (prf_re),
    .prf_RADDR(prf_raddr),
    .prf_RDATA(prf_rdata),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prf_val(input logic [AW-1:0] a);
    return {32'hFACE_0000 | {26'd0, a}, ~{26'd0, a}};
  endfunction

  // PRF behaviour: registered read, data available the cycle after RE.
  always @(posedge clk) begin
    for (int k = 0; k < NPORT; k++) begin
      prf_rdata[k*DW +: DW] <= prf_re[k] ? prf_val(prf_raddr[k*AW +: AW]) : 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] expect_data(input logic [AW-1:0] a);
`ifdef NCPU_PRF_RD_ARB_BYPASS_EN
    if (wb_we && (wb_addr == a)) return wb_data;
`endif
    return prf_val(a);
  endfunction

  task automatic model_step();
    int              q[$];
    int              j;
    logic [NREQ-1:0] e_ready;
    logic [NREQ-1:0] e_rsp;
    logic [NPORT-1:0] e_re;
    logic [NPORT*AW-1:0] e_raddr;
    if (!rst) m_ptr = 0;
    e_ready = '0;
    e_re    = '0;
    e_raddr = '0;
    if (!flush) begin
      for (int i = 0; i < NREQ; i++) begin
        j = (m_ptr + i) % NREQ;
        if (req_valid[j] && (q.size() < NPORT)) q.push_back(j);
      end
    end
    foreach (q[k]) begin
      e_ready[q[k]]         = 1'b1;
      e_re[k]               = 1'b1;
      e_raddr[k*AW +: AW]   = req_addr[q[k]*AW +: AW];
    end
    e_rsp = (rst && !flush) ? m_pend : '0;
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("prf_re", 64'(prf_re), 64'(e_re));
    chk("prf_raddr", 64'(prf_raddr), 64'(e_raddr));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    for (int i = 0; i < NREQ; i++) begin
      if (e_rsp[i]) chk("rsp_data", rsp_data[i*DW +: DW], m_data[i]);
    end
    chk("grants_le_nport", 64'($countones(req_ready) <= NPORT), 64'd1);
    if (rst && !flush && (req_valid == '1)) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          age[i] = 0;
        end else begin
          age[i]++;
          chk("starve_bound", 64'(age[i] <= ((NREQ + NPORT - 1) / NPORT) - 1), 64'd1);
        end
      end
    end else begin
      for (int i = 0; i < NREQ; i++) age[i] = 0;
    end
    if (!rst) begin
      m_pend = '0;
      m_ptr  = 0;
    end else begin
      m_pend = e_ready;
      foreach (q[k]) m_data[q[k]] = expect_data(req_addr[q[k]*AW +: AW]);
      if (flush) m_ptr = 0;
      else if (q.size() > 0) m_ptr = (q[q.size()-1] + 1) % NREQ;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sel;
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_addr  = {6'd5, 6'd3, 6'd2, 6'd1};
    wb_we     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    m_ptr     = 0;
    m_pend    = '0;
    for (int i = 0; i < NREQ; i++) begin
      m_data[i] = '0;
      age[i]    = 0;
    end
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'b0011);
    chk("rst_raddr", 64'(prf_raddr), 64'({6'd2, 6'd1}));
    tick();
    tick();

    // all four valid: 0,1 then 2,3 then 0,1
    rst = 1'b1;
    #1;
    chk("c0_ready", 64'(req_ready), 64'b0011);
    chk("c0_re", 64'(prf_re), 64'b11);
    chk("c0_rsp", 64'(rsp_valid), 64'd0);
    tick();
    chk("c1_ready", 64'(req_ready), 64'b1100);
    chk("c1_raddr", 64'(prf_raddr), 64'({6'd5, 6'd3}));
    chk("c1_rsp", 64'(rsp_valid), 64'b0011);
    chk("c1_data0", rsp_data[63:0], prf_val(6'd1));
    chk("c1_data1", rsp_data[127:64], prf_val(6'd2));
    tick();
    chk("c2_ready", 64'(req_ready), 64'b0011);
    chk("c2_rsp", 64'(rsp_valid), 64'b1100);
    chk("c2_data3", rsp_data[255:192], prf_val(6'd5));
    tick();

    // flush on a cycle that would grant two
    flush = 1'b1;
    #1;
    chk("fl_ready", 64'(req_ready), 64'd0);
    chk("fl_re", 64'(prf_re), 64'd0);
    chk("fl_rsp_same", 64'(rsp_valid), 64'd0);
    tick();
    flush     = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("fl_rsp_next", 64'(rsp_valid), 64'd0);
    tick();
    req_valid = 4'b1111;
    #1;
    chk("fl_ptr_zero", 64'(req_ready), 64'b0011);
    tick();
    tick();

    // single requester 2 with rr_ptr back at 0
    req_valid = 4'b0100;
    #1;
    chk("one_ready", 64'(req_ready), 64'b0100);
    chk("one_re", 64'(prf_re), 64'b01);
    chk("one_raddr0", 64'(prf_raddr[5:0]), 64'd3);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("one_rsp", 64'(rsp_valid), 64'b0100);
    chk("one_data", rsp_data[191:128], prf_val(6'd3));
    tick();

    // writeback to the granted address in the same cycle
    req_valid = 4'b1000;
    wb_we     = 1'b1;
    wb_addr   = 6'd5;
    wb_data   = 64'hDEAD;
    #1;
    chk("byp_ready", 64'(req_ready), 64'b1000);
    tick();
    wb_we     = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("byp_rsp", 64'(rsp_valid), 64'b1000);
`ifdef NCPU_PRF_RD_ARB_BYPASS_EN
    chk("byp_data", rsp_data[255:192], 64'hDEAD);
`else
    chk("byp_data", rsp_data[255:192], prf_val(6'd5));
`endif
    tick();

    // reset right after a grant
    req_valid = 4'b1111;
    #1;
    chk("r_ready", 64'(req_ready), 64'b0011);
    tick();
    rst       = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("r_rsp_killed", 64'(rsp_valid), 64'd0);
    tick();
    tick();
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("r_rsp_after", 64'(rsp_valid), 64'd0);
    chk("r_ready_after", 64'(req_ready), 64'b0011);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("r_rsp_new", 64'(rsp_valid), 64'b0011);
    tick();

    for (int c = 0; c < 10000; c++) begin
      req_valid = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom);
      req_addr  = 24'($urandom);
      flush     = ($urandom_range(0, 39) == 0);
      wb_we     = 1'($urandom_range(0, 1));
      sel       = int'($urandom_range(0, 3));
      wb_addr   = ($urandom_range(0, 1) == 1) ? req_addr[sel*AW +: AW] : 6'($urandom);
      wb_data   = {$urandom, $urandom};
      tick();
    end
    flush     = 1'b0;
    req_valid = '0;
    wb_we     = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prf_rd_arb.md
PRF_RD_ARB -- requirements
Module: prf_rd_arb

Interface
REQ-001 Parameter CONFIG_P_NREQ, default 2: log2 of the requester count; NREQ = 1<<CONFIG_P_NREQ.
REQ-002 Parameter CONFIG_P_NPORT, default 1: log2 of the PRF read-port count; NPORT = 1<<CONFIG_P_NPORT, and NPORT SHALL be <= NREQ.
REQ-003 Parameter CONFIG_PRF_AW, default 6: PRF address width.
REQ-004 Parameter CONFIG_DW, default 64: data width.
REQ-005 clk  in  1  the single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 flush  in  1  pipeline flush; kills grants and in-flight responses.
REQ-008 req_valid  in  NREQ  one read request per requester.
REQ-009 req_addr  in  NREQ*CONFIG_PRF_AW  read address per requester.
REQ-010 req_ready  out  NREQ  grant; a request is accepted when req_valid&req_ready.
REQ-011 prf_RE  out  NPORT  PRF read enable per port.
REQ-012 prf_RADDR  out  NPORT*CONFIG_PRF_AW  PRF read address per port.
REQ-013 prf_RDATA  in  NPORT*CONFIG_DW  PRF read data, valid the cycle after prf_RE.
REQ-014 wb_we, wb_addr, wb_data  in  1/CONFIG_PRF_AW/CONFIG_DW  PRF writeback port, observed for bypass.
REQ-015 rsp_valid  out  NREQ  one-cycle response strobe per requester.
REQ-016 rsp_data  out  NREQ*CONFIG_DW  response data per requester.

Function
REQ-017 Each cycle SHALL grant up to NPORT valid requesters, scanning ascending modulo NREQ from rr_ptr.
REQ-018 The k-th granted requester in scan order SHALL be assigned port k.
REQ-019 prf_RE[k]/prf_RADDR[k] SHALL be combinational from the assigned request; unassigned ports SHALL have prf_RE=0 and prf_RADDR=0.
REQ-020 req_ready SHALL depend only on req_valid, rr_ptr and flush, never on rsp state.
REQ-021 rr_ptr update: after any cycle with >=1 grant, rr_ptr SHALL become (last granted index + 1) mod NREQ; with no grant it SHALL hold.
REQ-022 Latency is exactly 1: a requester granted in cycle t SHALL see rsp_valid=1 for exactly one cycle at t+1.
REQ-023 rsp_data at t+1 SHALL be prf_RDATA of the port assigned at t, selected through a registered per-requester port index.
REQ-024 Responses SHALL NOT be backpressured; requesters SHALL accept rsp_valid unconditionally.
REQ-025 For a requester with rsp_valid=0, rsp_data SHALL be don't-care.
REQ-026 While flush=1: req_ready=0, prf_RE=0, and rsp_valid SHALL be 0 in the same cycle and the next cycle.
REQ-027 A flush SHALL reset rr_ptr to 0 at the next edge.
REQ-028 With all NREQ valid every cycle, each requester SHALL be granted at least once every ceil(NREQ/NPORT) cycles (no starvation).
REQ-029 Back-to-back requests from the same requester SHALL be granted in consecutive cycles when port capacity allows.

Reset
REQ-030 With rst low: rr_ptr=0, rsp_valid=0, registered port indices=0, bypass registers=0.
REQ-031 Combinational outputs SHALL follow REQ-019/026 as if flush=0 with rr_ptr=0.
REQ-032 A reset asserted mid-operation SHALL discard all in-flight responses; no rsp_valid SHALL appear after deassertion without a new grant.

Configuration
REQ-033 Macro NCPU_PRF_RD_ARB_BYPASS_EN.
- Defined: if wb_we=1 at cycle t and wb_addr equals the granted address at t, rsp_data at t+1 SHALL equal wb_data registered at t instead of prf_RDATA.
- Undefined: wb_* SHALL be ignored, no bypass registers exist, and rsp_data SHALL always equal prf_RDATA.

Verification
REQ-034 Reset release, NREQ=4, NPORT=2, req_valid=4'b1111 -> cycle0 grants 0,1 (ports 0,1); cycle1 grants 2,3; cycle2 grants 0,1; rsp_valid follows one cycle later.
REQ-035 req_valid=4'b0100 only, rr_ptr=0 -> req_ready=4'b0100, prf_RADDR[0]=req_addr[2], rsp_valid=4'b0100 next cycle with rsp_data[2]=prf_RDATA[0].
REQ-036 flush=1 in the same cycle as two grants would occur -> req_ready=0, prf_RE=0, rsp_valid=0 next cycle, rr_ptr=0 afterwards.
REQ-037 BYPASS_EN defined, request addr 5 with wb_we=1, wb_addr=5, wb_data=64'hDEAD in the same cycle -> rsp_data=64'hDEAD; with the macro undefined -> rsp_data=prf_RDATA.
REQ-038 rst pulled low the cycle after a grant -> no rsp_valid, rr_ptr=0, and the first grant after release starts from requester 0.
REQ-039 Random req_valid over 10k cycles -> scoreboard checks 1-cycle latency, port/data routing, at most NPORT grants per cycle, and the starvation bound of REQ-028.
